// File: rtl/div_unit_pkg.sv
// Shared types and constants for the iterative divider: ALU control codes,
// FSM state encoding, iteration counter width and a conditional-negate helper.
package div_unit_pkg;

    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;
    localparam logic [7:0] EXE_ADDU_OP = 8'b0010_0001;

    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

    function automatic logic [31:0] neg_if(input logic [31:0] v, input logic en);
        return en ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/div_unit_div_step.sv
// One restoring division iteration: shift {rem, quo} left, trial-subtract
// the divisor, keep the difference and set the quotient LSB when it fits.
module div_step (
    input  logic [31:0] rem,
    input  logic [31:0] quo,
    input  logic [31:0] divisor,
    output logic [31:0] rem_next,
    output logic [31:0] quo_next
);

    logic [32:0] shifted;
    logic [33:0] trial;

    assign shifted  = {rem, quo[31]};
    // Extra top bit acts as the borrow/sign of the 33-bit trial subtract.
    assign trial    = {1'b0, shifted} - {2'b00, divisor};
    assign rem_next = trial[33] ? shifted[31:0] : trial[31:0];
    assign quo_next = {quo[30:0], ~trial[33]};

endmodule

// File: rtl/div_unit.sv
// Iterative 32-bit signed/unsigned divider for the execute stage; stalls the
// pipeline for 33 cycles and presents {remainder, quotient} for HI/LO.
module div_unit
    import div_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  alucontrolE,
    input  logic        validE,
    input  logic        hold,
    input  logic        flush,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        div_stall,
    output logic        div_done,
    output logic [63:0] div_result
);

    div_state_t       state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      rem_r, quo_r, divisor_r;
    logic [31:0]      rem_next, quo_next;
    logic             sa_r, sb_r, signed_r;
    logic             is_div, signed_op, last_iter;
    logic [31:0]      a_mag, b_mag;

    assign signed_op = (alucontrolE == EXE_DIV_OP);
    assign is_div    = validE & ((alucontrolE == EXE_DIV_OP) | (alucontrolE == EXE_DIVU_OP));
    assign a_mag     = neg_if(a, signed_op & a[31]);
    assign b_mag     = neg_if(b, signed_op & b[31]);
    assign last_iter = (state == BUSY) && (cnt == {CNT_W{1'b1}});

    assign div_stall = ~flush & (((state == IDLE) & is_div) | (state == BUSY));
    assign div_done  = (state == DONE);

    div_step u_step (
        .rem      (rem_r),
        .quo      (quo_r),
        .divisor  (divisor_r),
        .rem_next (rem_next),
        .quo_next (quo_next)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (is_div)    state_next = BUSY;
            BUSY:    if (last_iter) state_next = DONE;
            DONE:    if (!hold)     state_next = IDLE;
            default:                state_next = IDLE;
        endcase
        if (flush) state_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            div_result <= 64'h0;
        end else begin
            if (state == BUSY) cnt <= cnt + 1'b1;
            else               cnt <= '0;
            // Sign correction is folded into the final-iteration write.
            if (last_iter && !flush)
                div_result <= {neg_if(rem_next, signed_r & sa_r),
                               neg_if(quo_next, signed_r & (sa_r ^ sb_r))};
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && is_div && !flush) begin
            rem_r     <= 32'd0;
            quo_r     <= a_mag;
            divisor_r <= b_mag;
            sa_r      <= a[31];
            sb_r      <= b[31];
            signed_r  <= signed_op;
        end else if (state == BUSY) begin
            rem_r <= rem_next;
            quo_r <= quo_next;
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit: latency, signed/unsigned results,
// boundary cases, flush, hold, reset and back-to-back operation.
module tb_div_unit;
    import div_unit_pkg::*;

    logic        clk, rst, validE, hold, flush;
    logic [7:0]  alucontrolE;
    logic [31:0] a, b;
    logic        div_stall, div_done;
    logic [63:0] div_result;

    int checks = 0;
    int errors = 0;

    div_unit dut (
        .clk         (clk),
        .rst         (rst),
        .alucontrolE (alucontrolE),
        .validE      (validE),
        .hold        (hold),
        .flush       (flush),
        .a           (a),
        .b           (b),
        .div_stall   (div_stall),
        .div_done    (div_done),
        .div_result  (div_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues a divide and follows it until the stall drops (bounded).
    task automatic do_div(input logic [7:0] op, input logic [31:0] aa, input logic [31:0] bb,
                          output int stalls, output logic done_seen, output logic [63:0] res);
        validE = 1'b1; alucontrolE = op; a = aa; b = bb;
        #1;
        stalls = 0;
        while (div_stall && stalls < 40) begin
            stalls++;
            step();
            a = $urandom; b = $urandom;
            #1;
        end
        done_seen = div_done;
        res       = div_result;
    endtask

    task automatic retire();
        validE = 1'b0; hold = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; validE = 1'b0; hold = 1'b0; flush = 1'b0;
        alucontrolE = 8'h00; a = 32'd0; b = 32'd0;
        step(); step();
        rst = 1'b0;
        #1;
        checks++; if (div_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", div_done); end
        checks++; if (div_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", div_stall); end
        checks++; if (div_result !== 64'h0) begin errors++; $display("FAIL reset_result: got %h want 0", div_result); end
    endtask

    task automatic test_divu_basic();
        int st; logic dn; logic [63:0] r;
        do_div(EXE_DIVU_OP, 32'd100, 32'd7, st, dn, r);
        checks++; if (st !== 33) begin errors++; $display("FAIL divu_latency: got %0d want 33", st); end
        checks++; if (dn !== 1'b1) begin errors++; $display("FAIL divu_done: got %b want 1", dn); end
        checks++; if (r !== {32'd2, 32'd14}) begin errors++; $display("FAIL divu_result: got %h want %h", r, {32'd2, 32'd14}); end
        retire();
        checks++; if (div_done !== 1'b0 || div_stall !== 1'b0) begin errors++; $display("FAIL divu_idle: done %b stall %b want 0 0", div_done, div_stall); end
    endtask

    task automatic test_signed();
        int st; logic dn; logic [63:0] r;
        do_div(EXE_DIV_OP, 32'hFFFF_FFF9, 32'd2, st, dn, r);
        checks++; if (r !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin errors++; $display("FAIL div_neg7_2: got %h want ffffffff_fffffffd", r); end
        retire();
        do_div(EXE_DIV_OP, 32'd7, 32'hFFFF_FFFE, st, dn, r);
        checks++; if (r !== {32'h0000_0001, 32'hFFFF_FFFD}) begin errors++; $display("FAIL div_7_neg2: got %h want 00000001_fffffffd", r); end
        retire();
        do_div(EXE_DIV_OP, 32'hFFFF_FF9C, 32'hFFFF_FFF9, st, dn, r);
        checks++; if (r !== {32'hFFFF_FFFE, 32'h0000_000E}) begin errors++; $display("FAIL div_neg100_neg7: got %h want fffffffe_0000000e", r); end
        retire();
    endtask

    task automatic test_boundary();
        int st; logic dn; logic [63:0] r;
        do_div(EXE_DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF, st, dn, r);
        checks++; if (dn !== 1'b1) begin errors++; $display("FAIL ovf_done: got %b want 1", dn); end
        checks++; if (r !== {32'h0, 32'h8000_0000}) begin errors++; $display("FAIL ovf_result: got %h want 00000000_80000000", r); end
        retire();
        do_div(EXE_DIVU_OP, 32'd5, 32'd0, st, dn, r);
        checks++; if (st !== 33) begin errors++; $display("FAIL div0_latency: got %0d want 33", st); end
        checks++; if (r !== {32'd5, 32'hFFFF_FFFF}) begin errors++; $display("FAIL div0_result: got %h want 00000005_ffffffff", r); end
        retire();
        do_div(EXE_DIVU_OP, 32'hFFFF_FFFF, 32'd16, st, dn, r);
        checks++; if (r !== {32'd15, 32'h0FFF_FFFF}) begin errors++; $display("FAIL divu_max: got %h want 0000000f_0fffffff", r); end
        retire();
    endtask

    task automatic test_flush();
        logic [63:0] prev;
        prev = div_result;
        validE = 1'b1; alucontrolE = EXE_DIVU_OP; a = 32'd1000; b = 32'd3;
        repeat (10) step();
        checks++; if (div_stall !== 1'b1) begin errors++; $display("FAIL flush_busy: stall %b want 1", div_stall); end
        flush = 1'b1; validE = 1'b0;
        #1;
        checks++; if (div_stall !== 1'b0) begin errors++; $display("FAIL flush_stall_now: got %b want 0", div_stall); end
        step();
        flush = 1'b0;
        #1;
        checks++; if (div_stall !== 1'b0 || div_done !== 1'b0) begin errors++; $display("FAIL flush_idle: stall %b done %b want 0 0", div_stall, div_done); end
        repeat (30) step();
        checks++; if (div_done !== 1'b0) begin errors++; $display("FAIL flush_no_done: got %b want 0", div_done); end
        checks++; if (div_result !== prev) begin errors++; $display("FAIL flush_result: got %h want %h", div_result, prev); end
    endtask

    task automatic test_hold();
        int st; logic dn; logic [63:0] r;
        do_div(EXE_DIVU_OP, 32'd50, 32'd6, st, dn, r);
        checks++; if (r !== {32'd2, 32'd8}) begin errors++; $display("FAIL hold_result: got %h want 00000002_00000008", r); end
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (div_done !== 1'b1 || div_stall !== 1'b0) begin errors++; $display("FAIL hold_done_%0d: done %b stall %b want 1 0", i, div_done, div_stall); end
            checks++; if (div_result !== {32'd2, 32'd8}) begin errors++; $display("FAIL hold_stable_%0d: got %h want 00000002_00000008", i, div_result); end
        end
        hold = 1'b0;
        #1;
        checks++; if (div_done !== 1'b1) begin errors++; $display("FAIL hold_last_done: got %b want 1", div_done); end
        retire();
        checks++; if (div_done !== 1'b0 || div_stall !== 1'b0) begin errors++; $display("FAIL hold_release: done %b stall %b want 0 0", div_done, div_stall); end
    endtask

    task automatic test_back_to_back();
        int st; logic dn; logic [63:0] r;
        do_div(EXE_DIVU_OP, 32'd9, 32'd4, st, dn, r);
        checks++; if (r !== {32'd1, 32'd2}) begin errors++; $display("FAIL b2b_first: got %h want 00000001_00000002", r); end
        alucontrolE = EXE_DIV_OP; a = 32'hFFFF_FFF6; b = 32'd3;
        step();
        checks++; if (div_stall !== 1'b1) begin errors++; $display("FAIL b2b_restart: stall %b want 1", div_stall); end
        do_div(EXE_DIV_OP, 32'hFFFF_FFF6, 32'd3, st, dn, r);
        checks++; if (st !== 33) begin errors++; $display("FAIL b2b_latency: got %0d want 33", st); end
        checks++; if (r !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin errors++; $display("FAIL b2b_second: got %h want ffffffff_fffffffd", r); end
        retire();
    endtask

    task automatic test_reset_mid();
        validE = 1'b1; alucontrolE = EXE_DIVU_OP; a = 32'd77; b = 32'd5;
        repeat (20) step();
        rst = 1'b1; validE = 1'b0;
        step();
        rst = 1'b0;
        #1;
        checks++; if (div_result !== 64'h0) begin errors++; $display("FAIL rstmid_result: got %h want 0", div_result); end
        checks++; if (div_done !== 1'b0 || div_stall !== 1'b0) begin errors++; $display("FAIL rstmid_ctrl: done %b stall %b want 0 0", div_done, div_stall); end
        repeat (15) step();
        checks++; if (div_done !== 1'b0) begin errors++; $display("FAIL rstmid_no_done: got %b want 0", div_done); end
    endtask

    task automatic test_non_div();
        int stall_seen;
        stall_seen = 0;
        validE = 1'b1; alucontrolE = EXE_ADDU_OP; a = 32'd100; b = 32'd7;
        for (int i = 0; i < 5; i++) begin
            #1; if (div_stall) stall_seen++;
            step();
        end
        validE = 1'b0; alucontrolE = EXE_DIV_OP;
        for (int i = 0; i < 5; i++) begin
            #1; if (div_stall) stall_seen++;
            step();
        end
        checks++; if (stall_seen !== 0) begin errors++; $display("FAIL non_div_stall: got %0d stall cycles want 0", stall_seen); end
        checks++; if (div_done !== 1'b0) begin errors++; $display("FAIL non_div_done: got %b want 0", div_done); end
    endtask

    initial begin
        test_reset();
        test_divu_basic();
        test_signed();
        test_boundary();
        test_flush();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        test_non_div();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative 32-bit signed/unsigned divider in the execute stage. It consumes the 8-bit ALU control code produced by the decode-stage ALU decoder and acts on the `EXE_DIV_OP` and `EXE_DIVU_OP` encodings. While a divide runs it holds the pipeline with a stall request. It then presents the {HI, LO} = {remainder, quotient} pair for the HI/LO write path.

## Interface
- Parameters: none. The width is fixed at 32 by the ISA.
- `clk`  in  1  system clock; all state changes on its rising edge
- `rst`  in  1  synchronous, active-high reset
- `alucontrolE`  in  8  ALU control of the instruction in execute
- `validE`  in  1  execute-stage instruction is valid (not a bubble)
- `hold`  in  1  pipeline frozen by a cause other than this unit
- `flush`  in  1  exception/flush; cancels any divide in progress
- `a`  in  32  dividend (rs value after forwarding)
- `b`  in  32  divisor (rt value after forwarding)
- `div_stall`  out  1  combinational stall request to the hazard unit
- `div_done`  out  1  result valid this cycle
- `div_result`  out  64  {remainder[31:0], quotient[31:0]}

## Operation
- `is_div` = `validE` & (`alucontrolE` == `EXE_DIV_OP` | `EXE_DIVU_OP`). `signed_op` = (`alucontrolE` == `EXE_DIV_OP`).
- States: IDLE, BUSY, DONE.
- **IDLE**
  - If `is_div` & !`flush`: latch |a| and |b| (magnitude if `signed_op`, raw otherwise), latch the sign flags `a[31]`/`b[31]` and `signed_op`.
  - Clear the partial remainder, load the counter with 0, and go to BUSY.
- **BUSY**
  - One restoring iteration per cycle.
  - Shift {rem, quo} left by 1; trial = rem[32:0] − {1'b0, |b|}.
  - If trial ≥ 0, rem ← trial and the quotient LSB is 1; otherwise the LSB is 0.
  - The counter increments every cycle; after iteration 31 (counter == 31) go to DONE.
- **DONE**
  - `div_done` = 1 and `div_result` is valid.
  - Stay in DONE while `hold` = 1. Go to IDLE when `hold` = 0.
  - An instruction still sitting in execute is never re-issued.
- **Sign fix**, applied on the BUSY→DONE transition into the result register:
  - Quotient is negated if `signed_op` & (sa ^ sb).
  - Remainder is negated if `signed_op` & sa.
- **Divide by zero**: the divisor is not special-cased, so the result is whatever the iteration produces.
  - For an unsigned divide this is quotient = 0xFFFF_FFFF, remainder = a.
  - Latency is unchanged.
- **Overflow**: 0x8000_0000 / 0xFFFF_FFFF (signed) gives quotient 0x8000_0000, remainder 0, with no trap.
- **Arithmetic width**:
  - Magnitudes are 32-bit unsigned, so |0x8000_0000| = 0x8000_0000.
  - The trial subtract is 33-bit.
- **`div_stall`** = !`flush` & ((IDLE & `is_div`) | BUSY).
- **`flush`** in any state: go to IDLE next cycle, `div_done` = 0, result not updated. `flush` has priority over `hold` and `is_div`.
- **`rst`**: state IDLE, counter 0, `div_result` 64'h0, `div_done` 0. A reset mid-divide abandons the operation.

## Timing
- Cycle 0, IDLE with `is_div`: `div_stall` = 1 and operands are captured.
- Cycles 1–32 (BUSY, 32 cycles): `div_stall` = 1.
- Cycle 33 (DONE): `div_stall` = 0 and `div_done` = 1. The HI/LO write happens at the end of this cycle if `hold` = 0.
- Total: 33 stall cycles, result on the 34th cycle.
- `div_result` holds its value from DONE until the next completed divide.
- `a`/`b` may change after cycle 0 without effect on the result.
- Back-to-back divides: a new `is_div` is sampled in IDLE the cycle after DONE, so there is no bubble beyond the DONE cycle.

## Structure
- ALU control encodings (`EXE_DIV_OP`, `EXE_DIVU_OP`) come from the shared defines header. No new shared constants are added.
- State encoding and counter width (5 bits) are local parameters.
- One natural sub-module, `div_step`: a combinational single restoring iteration.
  - Inputs: {rem, quo}, divisor.
  - Output: the next {rem, quo}.
  - It is instantiated once.
- Sign handling and the FSM live in `div_unit`.

## Test plan
1. DIVU a=100, b=7 → stall high for exactly 33 cycles, then `div_done`; `div_result` = {32'd2, 32'd14}.
2. DIV a=−7 (0xFFFF_FFF9), b=2 → quotient 0xFFFF_FFFD (−3), remainder 0xFFFF_FFFF (−1). Also a=7, b=−2 → quotient −3, remainder +1.
3. DIV 0x8000_0000 / 0xFFFF_FFFF → {0x0000_0000, 0x8000_0000}, no hang. DIVU a=5, b=0 → {0x0000_0005, 0xFFFF_FFFF}, same 33-cycle latency.
4. `flush` asserted at BUSY cycle 10 → next cycle IDLE, stall 0, no `div_done`, `div_result` unchanged from the prior divide.
5. `hold` = 1 for 3 cycles at DONE → `div_done` stays 1 and `div_result` is stable for 4 cycles. No restart occurs although `is_div` is still high; IDLE follows after `hold` falls.
6. `rst` at BUSY cycle 20 → next cycle IDLE, `div_result` = 0, `div_done` = 0. Non-divide codes (e.g. `EXE_ADDU_OP`) or `validE` = 0 → stall never asserted.
